// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Multicycle MIPS control unit: state register, next-state logic and
// Moore-style output decode in one block. All datapath strobes come straight
// from the current state, plus opcode/zero/mem_ready; no output register.
//
// Optional feature: define MC_CTRL_BNE_EN to decode bne (opcode 000101) into
// the BRANCH state with branch_ne=1. Without it, 000101 is illegal and
// branch_ne is tied to 0.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   opcode[5:0]       IR[31:26], stable from end of FETCH
//   zero              ALU zero flag
//   mem_ready         memory finished the current request this cycle
//   pc_write .. alu_src_a   1-bit datapath strobes/selects
//   pc_src[1:0]       00 ALU, 01 ALUOut, 10 jump target
//   alu_src_b[1:0]    00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   alu_op            0 ADD, 1 SUB, 2 FUNCT, 3 AND, 4 OR
//   illegal_op        pulse on undecodable opcode/state
//   instr_done        pulse on an instruction's final cycle
//   state[3:0]        current state (debug)
module mc_control_fsm #(
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_en,
  output logic                branch,
  output logic                branch_ne,
  output logic                ir_write,
  output logic                reg_write,
  output logic                i_or_d,
  output logic                mem_req,
  output logic                mem_write,
  output logic                mem_toreg,
  output logic                reg_dst,
  output logic                alu_src_a,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_op,
  output logic                instr_done,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(4);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    mem_toreg  = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    illegal_op = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        // PC/IR update only on the completing cycle, so a stalled fetch
        // still produces a single pulse.
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYP:                   state_d = S_EXEC;
          OP_BEQ:                    state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:                    state_d = S_BRANCH;
`endif
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
          OP_J:                      state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Only lw/sw reach here; anything else falls back to FETCH.
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_toreg  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        branch     = 1'b1;
        pc_src     = 2'b01;
        instr_done = 1'b1;
`ifdef MC_CTRL_BNE_EN
        branch_ne  = (opcode == OP_BNE);
`endif
        state_d    = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ANDI)     alu_op = ALU_AND;
        else if (opcode == OP_ORI) alu_op = ALU_OR;
        else                       alu_op = ALU_ADD;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        illegal_op = 1'b1;
        state_d    = S_FETCH;
      end
    endcase

    // Outputs are combinational, so an asserted reset must silence them
    // directly rather than waiting for the state register.
    if (!rst_n) begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      i_or_d     = 1'b0;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      mem_toreg  = 1'b0;
      reg_dst    = 1'b0;
      alu_src_a  = 1'b0;
      pc_src     = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign pc_en = pc_write | (branch & (zero ^ branch_ne));

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks lw, stalled fetch + beq, ori,
// R-type, j, illegal opcodes, bne (either build) and reset during sw.
module tb_mc_control_fsm;

  localparam int ALU_OP_W = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [5:0]          opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_write, pc_en, branch, branch_ne, ir_write, reg_write;
  logic                i_or_d, mem_req, mem_write, mem_toreg, reg_dst, alu_src_a;
  logic [1:0]          pc_src, alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                illegal_op, instr_done;
  logic [3:0]          state;

  int n_checks = 0;
  int n_errors = 0;

  mc_control_fsm #(.ALU_OP_W(ALU_OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_en(pc_en), .branch(branch), .branch_ne(branch_ne),
    .ir_write(ir_write), .reg_write(reg_write), .i_or_d(i_or_d), .mem_req(mem_req),
    .mem_write(mem_write), .mem_toreg(mem_toreg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
    #3;
    chk("rst_state",    32'(state), 0);
    chk("rst_mem_req",  32'(mem_req), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_srcb",     32'(alu_src_b), 0);
    chk("rst_pc_en",    32'(pc_en), 0);
    #9 rst_n = 1'b1;   // t=12, between edges
    #1;
    // lw, zero wait: 0,1,2,3,4,0
    chk("lw_f_state", 32'(state), 0);
    chk("lw_f_req",   32'(mem_req), 1);
    chk("lw_f_pcw",   32'(pc_write), 1);
    chk("lw_f_irw",   32'(ir_write), 1);
    chk("lw_f_srcb",  32'(alu_src_b), 1);
    chk("lw_f_pcen",  32'(pc_en), 1);
    cyc();
    chk("lw_d_state", 32'(state), 1);
    chk("lw_d_pcw",   32'(pc_write), 0);
    chk("lw_d_srcb",  32'(alu_src_b), 3);
    chk("lw_d_ill",   32'(illegal_op), 0);
    cyc();
    chk("lw_ma_state", 32'(state), 2);
    chk("lw_ma_srca",  32'(alu_src_a), 1);
    chk("lw_ma_srcb",  32'(alu_src_b), 2);
    chk("lw_ma_op",    32'(alu_op), 0);
    cyc();
    chk("lw_mr_state", 32'(state), 3);
    chk("lw_mr_req",   32'(mem_req), 1);
    chk("lw_mr_iord",  32'(i_or_d), 1);
    chk("lw_mr_done",  32'(instr_done), 0);
    cyc();
    chk("lw_wb_state", 32'(state), 4);
    chk("lw_wb_rw",    32'(reg_write), 1);
    chk("lw_wb_m2r",   32'(mem_toreg), 1);
    chk("lw_wb_done",  32'(instr_done), 1);
    chk("lw_wb_pcw",   32'(pc_write), 0);
    cyc();
    chk("lw_end_state", 32'(state), 0);

    // Stalled fetch (3 wait cycles) then beq
    opcode = 6'b000100; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("stall_state", 32'(state), 0);
      chk("stall_req",   32'(mem_req), 1);
      chk("stall_pcw",   32'(pc_write), 0);
      chk("stall_irw",   32'(ir_write), 0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("stall_rel_state", 32'(state), 0);
    chk("stall_rel_pcw",   32'(pc_write), 1);
    chk("stall_rel_irw",   32'(ir_write), 1);
    cyc();
    chk("beq_d_state", 32'(state), 1);
    cyc();
    chk("beq_state",  32'(state), 8);
    chk("beq_pcen1",  32'(pc_en), 1);
    chk("beq_pcsrc",  32'(pc_src), 1);
    chk("beq_op",     32'(alu_op), 1);
    chk("beq_srcb",   32'(alu_src_b), 0);
    chk("beq_bne",    32'(branch_ne), 0);
    chk("beq_done",   32'(instr_done), 1);
    zero = 1'b0;
    #1;
    chk("beq_pcen0",  32'(pc_en), 0);
    cyc();
    chk("beq_end_state", 32'(state), 0);

    // ori
    opcode = 6'b001101;
    cyc(); cyc();
    chk("ori_ex_state", 32'(state), 9);
    chk("ori_ex_op",    32'(alu_op), 4);
    chk("ori_ex_srcb",  32'(alu_src_b), 2);
    cyc();
    chk("ori_wb_state", 32'(state), 10);
    chk("ori_wb_rw",    32'(reg_write), 1);
    chk("ori_wb_rdst",  32'(reg_dst), 0);
    chk("ori_wb_m2r",   32'(mem_toreg), 0);
    chk("ori_wb_done",  32'(instr_done), 1);
    cyc();

    // andi: only the IMMEX alu_op differs
    opcode = 6'b001100;
    cyc(); cyc();
    chk("andi_ex_op", 32'(alu_op), 3);
    cyc(); cyc();

    // R-type
    opcode = 6'b000000;
    cyc(); cyc();
    chk("r_ex_state", 32'(state), 6);
    chk("r_ex_op",    32'(alu_op), 2);
    chk("r_ex_srca",  32'(alu_src_a), 1);
    cyc();
    chk("r_wb_state", 32'(state), 7);
    chk("r_wb_rdst",  32'(reg_dst), 1);
    chk("r_wb_rw",    32'(reg_write), 1);
    cyc();

    // j
    opcode = 6'b000010;
    cyc(); cyc();
    chk("j_state", 32'(state), 11);
    chk("j_pcw",   32'(pc_write), 1);
    chk("j_pcsrc", 32'(pc_src), 2);
    chk("j_pcen",  32'(pc_en), 1);
    chk("j_done",  32'(instr_done), 1);
    cyc();
    chk("j_end_state", 32'(state), 0);

    // Illegal opcode
    opcode = 6'b111111;
    cyc();
    chk("ill_state", 32'(state), 1);
    chk("ill_flag",  32'(illegal_op), 1);
    cyc();
    chk("ill_next",  32'(state), 0);
    chk("ill_clear", 32'(illegal_op), 0);

    // bne
    opcode = 6'b000101; zero = 1'b0;
    cyc();
`ifdef MC_CTRL_BNE_EN
    chk("bne_d_ill", 32'(illegal_op), 0);
    cyc();
    chk("bne_state", 32'(state), 8);
    chk("bne_ne",    32'(branch_ne), 1);
    chk("bne_pcen",  32'(pc_en), 1);
    cyc();
`else
    chk("bne_d_ill", 32'(illegal_op), 1);
    cyc();
    chk("bne_next",  32'(state), 0);
`endif

    // sw, zero wait
    opcode = 6'b101011; mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("sw_state", 32'(state), 5);
    chk("sw_wr",    32'(mem_write), 1);
    chk("sw_done",  32'(instr_done), 1);
    cyc();
    chk("sw_end_state", 32'(state), 0);

    // sw stalled in MEMWR, then reset
    cyc(); cyc(); cyc();
    mem_ready = 1'b0;
    #1;
    chk("swr_state", 32'(state), 5);
    chk("swr_wr",    32'(mem_write), 1);
    chk("swr_done",  32'(instr_done), 0);
    rst_n = 1'b0;
    #1;
    chk("swr_rst_wr",    32'(mem_write), 0);
    chk("swr_rst_state", 32'(state), 0);
    chk("swr_rst_done",  32'(instr_done), 0);
    chk("swr_rst_req",   32'(mem_req), 0);
    #2 rst_n = 1'b1;
    #1;
    chk("swr_rel_state", 32'(state), 0);
    chk("swr_rel_req",   32'(mem_req), 1);
    chk("swr_rel_iord",  32'(i_or_d), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Complete multicycle control unit for the MIPS core: state register, next-state logic and Moore output decode in one block. It replaces the stand-alone output decoder and drives every datapath strobe from the current state. It adds a memory wait handshake, immediate-logic instructions and a parametrised ALU-op width, and flags illegal opcodes. It sits between the instruction register opcode field / ALU zero flag and the datapath muxes and enables.

## Interface
- ALU_OP_W, 3, width of alu_op (≥3)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from end of FETCH onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current request this cycle
- pc_write, pc_en, branch, branch_ne, ir_write, reg_write, i_or_d, mem_req, mem_write, mem_toreg, reg_dst, alu_src_a  out  1 each  datapath strobes/selects
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 FUNCT, 3 AND, 4 OR (zero-extended)
- illegal_op  out  1  one-cycle pulse on undecodable opcode/state
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- state  out  4  current state, for debug

## Operation
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11; codes 12–15 are unused.
- Transitions:
  - FETCH→DECODE when mem_ready, otherwise stay.
  - DECODE on opcode: 100011/101011→MEMADR; 000000→EXEC; 000100→BRANCH; 001000/001100/001101→IMMEX; 000010→JUMP; anything else→FETCH with illegal_op=1.
  - MEMADR→MEMRD for lw, →MEMWR for sw.
  - MEMRD→MEMWB when mem_ready. MEMWR→FETCH when mem_ready.
  - EXEC→ALUWB. IMMEX→IMMWB.
  - MEMWB, ALUWB, BRANCH, IMMWB and JUMP→FETCH.
  - Unused codes→FETCH with illegal_op=1.
- Outputs are 0 unless listed:
  - FETCH: mem_req=1, alu_src_b=01, alu_op=ADD, pc_src=00; pc_write=ir_write=mem_ready.
  - DECODE: alu_src_b=11, alu_op=ADD.
  - MEMADR: alu_src_a=1, alu_src_b=10, ADD.
  - MEMRD: mem_req=1, i_or_d=1.
  - MEMWB: reg_write=1, mem_toreg=1, instr_done=1.
  - MEMWR: mem_req=1, mem_write=1, i_or_d=1; instr_done=mem_ready.
  - EXEC: alu_src_a=1, alu_src_b=00, FUNCT.
  - ALUWB: reg_write=1, reg_dst=1, instr_done=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, branch=1, pc_src=01, instr_done=1.
  - IMMEX: alu_src_a=1, alu_src_b=10; ADD for 001000, AND for 001100, OR for 001101.
  - IMMWB: reg_write=1, instr_done=1.
  - JUMP: pc_write=1, pc_src=10, instr_done=1.
- pc_en = pc_write | (branch & (zero ^ branch_ne)).

## Timing
- Reset is asynchronous: state goes to FETCH immediately. While rst_n=0, all 1-bit outputs, alu_op, pc_src and alu_src_b are forced to 0. FETCH decode begins at the first edge after rst_n deasserts.
- Reset asserted mid-instruction aborts it with no further strobes; the next instruction is fetched from the PC as held.
- Outputs are combinational from state plus opcode/zero/mem_ready; there is no output register.
- Zero-wait latency (cycles): lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- pc_write/ir_write pulse exactly once per fetch, even when mem_ready stays low for several cycles.
- mem_req stays high and the address select stays stable until mem_ready.

## Configuration
- MC_CTRL_BNE_EN defined:
  - opcode 000101 decodes DECODE→BRANCH.
  - branch_ne=1 in BRANCH for 000101 and 0 for 000100.
- Undefined:
  - 000101 is illegal (DECODE→FETCH, illegal_op pulse).
  - branch_ne is tied to 0.

## Test plan
- Reset release, mem_ready=1, opcode 100011: states 0,1,2,3,4,0. pc_write=1 only in cycle 0; reg_write & mem_toreg in state 4; instr_done once.
- FETCH with mem_ready low for 3 cycles, then high: state holds 0 for 4 cycles, mem_req=1 throughout, single pc_write/ir_write pulse.
- opcode 000100, zero=1 → pc_en=1 in BRANCH with pc_src=01, alu_op=1. With zero=0 → pc_en=0.
- opcode 001101 → IMMEX alu_op=4, then IMMWB reg_write=1, reg_dst=0, mem_toreg=0.
- opcode 111111 → illegal_op=1 in DECODE, next state 0. Opcode 000101 → BRANCH if MC_CTRL_BNE_EN, else illegal.
- rst_n low during MEMWR with mem_ready=0 → mem_write drops asynchronously to 0, state=0, no instr_done.
